// File: rtl/countdown_timer_pkg.sv
// Shared definitions for the countdown timer: FSM state encoding and the
// active-low seven-segment glyph table (bit0 = a ... bit6 = g).
package countdown_timer_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    RUN    = 2'd1,
    PAUSED = 2'd2,
    DONE   = 2'd3
  } state_t;

  // Index 0 is the leftmost entry, so the table reads 0..F in order.
  localparam logic [0:15][6:0] SEG7_TABLE = {
    7'b1000000,  // 0
    7'b1111001,  // 1
    7'b0100100,  // 2
    7'b0110000,  // 3
    7'b0011001,  // 4
    7'b0010010,  // 5
    7'b0000010,  // 6
    7'b1111000,  // 7
    7'b0000000,  // 8
    7'b0010000,  // 9
    7'b0001000,  // A
    7'b0000011,  // b
    7'b1000110,  // C
    7'b0100001,  // d
    7'b0000110,  // E
    7'b0001110   // F
  };

endpackage

// File: rtl/seg7_decoder.sv
// Hex nibble to active-low seven-segment pattern, purely combinational.
module seg7_decoder (
  input  logic [3:0] digit,
  output logic [6:0] seg
);
  import countdown_timer_pkg::*;

  assign seg = SEG7_TABLE[digit];

endmodule

// File: rtl/countdown_timer.sv
// Loadable 8-bit down-counter with clock prescaler, run/pause/done FSM and
// two seven-segment digit outputs.
module countdown_timer #(
  parameter int PRESCALE = 50000000
) (
  input  logic       clk,
  input  logic       clr,
  input  logic       load,
  input  logic [7:0] load_value,
  input  logic       start,
  input  logic       pause,
  output logic [7:0] count,
  output logic       running,
  output logic       expired,
  output logic       done,
  output logic [6:0] hex0,
  output logic [6:0] hex1
);
  import countdown_timer_pkg::*;

  localparam int PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [PW-1:0] PRESC_LAST = PW'(PRESCALE - 1);

  state_t        state, state_nx;
  logic [7:0]    count_nx;
  logic [PW-1:0] presc, presc_nx;
  logic          done_nx;

  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      state <= IDLE;
      count <= '0;
      presc <= '0;
      done  <= 1'b0;
    end else begin
      state <= state_nx;
      count <= count_nx;
      presc <= presc_nx;
      done  <= done_nx;
    end
  end

  // load overrides every state; done is a pulse, so it defaults low.
  always_comb begin
    state_nx = state;
    count_nx = count;
    presc_nx = presc;
    done_nx  = 1'b0;
    if (load) begin
      count_nx = load_value;
      presc_nx = '0;
      state_nx = IDLE;
    end else begin
      unique case (state)
        IDLE: begin
          if (start) begin
            if (count != 8'd0) begin
              state_nx = RUN;
              presc_nx = '0;
            end else begin
              state_nx = DONE;
              done_nx  = 1'b1;
            end
          end
        end
        RUN: begin
          // Pause wins over a due tick; the prescaler phase is kept.
          if (pause) begin
            state_nx = PAUSED;
          end else if (presc == PRESC_LAST) begin
            presc_nx = '0;
            count_nx = count - 8'd1;
            if (count == 8'd1) begin
              state_nx = DONE;
              done_nx  = 1'b1;
            end
          end else begin
            presc_nx = presc + PW'(1);
          end
        end
        PAUSED: begin
          if (start) state_nx = RUN;
        end
        DONE: begin
          count_nx = '0;
        end
        default: state_nx = IDLE;
      endcase
    end
  end

  assign running = (state == RUN);
  assign expired = (state == DONE);

  seg7_decoder u_seg_lo (
    .digit (count[3:0]),
    .seg   (hex0)
  );

  seg7_decoder u_seg_hi (
    .digit (count[7:4]),
    .seg   (hex1)
  );

endmodule

// File: tb/tb_countdown_timer.sv
// Scoreboard bench for countdown_timer: stimulus queues every expected output
// change with its clock index; a negedge monitor pops and compares each change.
module tb_countdown_timer;

  localparam int PRESCALE = 4;

  logic       clk = 1'b0;
  logic       clr = 1'b0;
  logic       load = 1'b0;
  logic [7:0] load_value = 8'h00;
  logic       start = 1'b0;
  logic       pause = 1'b0;
  logic [7:0] count;
  logic       running, expired, done;
  logic [6:0] hex0, hex1;

  countdown_timer #(.PRESCALE(PRESCALE)) dut (
    .clk        (clk),
    .clr        (clr),
    .load       (load),
    .load_value (load_value),
    .start      (start),
    .pause      (pause),
    .count      (count),
    .running    (running),
    .expired    (expired),
    .done       (done),
    .hex0       (hex0),
    .hex1       (hex1)
  );

  always #5 clk = ~clk;

  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct packed {
    logic [31:0] cyc;
    logic [7:0]  count;
    logic        done;
    logic        running;
    logic        expired;
    logic [6:0]  hex0;
    logic [6:0]  hex1;
  } ev_t;

  ev_t exp_q[$];
  int  checks = 0;
  int  errors = 0;

  logic [6:0] seg_ref [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                               7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};

  // Last expectation queued; only changes are queued. st: 0 idle 1 run 2 paused 3 done.
  logic [7:0] last_cnt = 8'h00;
  logic       last_done = 1'b0;
  int         last_st = 0;

  task automatic push(input int unsigned at, input logic [7:0] c, input logic d, input int st);
    ev_t e;
    if (c == last_cnt && d == last_done && st == last_st) return;
    e.cyc     = at;
    e.count   = c;
    e.done    = d;
    e.running = (st == 1);
    e.expired = (st == 3);
    e.hex0    = seg_ref[c[3:0]];
    e.hex1    = seg_ref[c[7:4]];
    exp_q.push_back(e);
    last_cnt  = c;
    last_done = d;
    last_st   = st;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, req);
    end
  endtask

  // Monitor: any change of the visible outputs is one DUT event.
  initial begin
    ev_t prev, cur, e;
    prev = '{cyc: 32'd0, count: 8'h00, done: 1'b0, running: 1'b0, expired: 1'b0,
             hex0: 7'h40, hex1: 7'h40};
    forever begin
      @(negedge clk);
      cur = '{cyc: cyc, count: count, done: done, running: running, expired: expired,
              hex0: hex0, hex1: hex1};
      if ({cur.count, cur.done, cur.running, cur.expired, cur.hex0, cur.hex1} !==
          {prev.count, prev.done, prev.running, prev.expired, prev.hex0, prev.hex1}) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL event unexpected at cyc %0d: count=%h done=%b run=%b exp=%b hex1=%b hex0=%b",
                   cur.cyc, cur.count, cur.done, cur.running, cur.expired, cur.hex1, cur.hex0);
        end else begin
          e = exp_q.pop_front();
          if (cur !== e) begin
            errors++;
            $display("FAIL event got cyc=%0d count=%h done=%b run=%b exp=%b hex1=%b hex0=%b expected cyc=%0d count=%h done=%b run=%b exp=%b hex1=%b hex0=%b",
                     cur.cyc, cur.count, cur.done, cur.running, cur.expired, cur.hex1, cur.hex0,
                     e.cyc, e.count, e.done, e.running, e.expired, e.hex1, e.hex0);
          end
        end
        prev = cur;
      end
    end
  end

  task automatic step();
    @(negedge clk);
  endtask

  task automatic wait_until(input int unsigned t);
    while (cyc < t) @(negedge clk);
  endtask

  task automatic do_load(input logic [7:0] v);
    load       = 1'b1;
    load_value = v;
    push(cyc + 1, v, 1'b0, 0);
    step();
    load = 1'b0;
  endtask

  int unsigned t0, r, s0;

  initial begin
    repeat (2) step();
    chk("reset_count", {24'd0, count}, 32'd0);
    chk("reset_running", {31'd0, running}, 32'd0);
    chk("reset_expired", {31'd0, expired}, 32'd0);
    chk("reset_done", {31'd0, done}, 32'd0);
    chk("reset_hex0", {25'd0, hex0}, 32'h40);
    chk("reset_hex1", {25'd0, hex1}, 32'h40);
    clr = 1'b1;
    step();

    // Load 3 and run to expiry
    do_load(8'h03);
    start = 1'b1;
    t0 = cyc + 1;
    push(t0, 8'h03, 1'b0, 1);
    push(t0 + 4, 8'h02, 1'b0, 1);
    push(t0 + 8, 8'h01, 1'b0, 1);
    push(t0 + 12, 8'h00, 1'b1, 3);
    push(t0 + 13, 8'h00, 1'b0, 3);
    step();
    start = 1'b0;
    wait_until(t0 + 15);
    start = 1'b1;
    pause = 1'b1;
    step();
    step();
    start = 1'b0;
    pause = 1'b0;

    // Pause with prescaler at 2, resume, then pause exactly on a due tick
    do_load(8'h05);
    start = 1'b1;
    t0 = cyc + 1;
    push(t0, 8'h05, 1'b0, 1);
    step();
    start = 1'b0;
    wait_until(t0 + 2);
    pause = 1'b1;
    push(t0 + 3, 8'h05, 1'b0, 2);
    step();
    step();
    pause = 1'b0;
    wait_until(t0 + 12);
    start = 1'b1;
    r = cyc + 1;
    push(r, 8'h05, 1'b0, 1);
    push(r + 2, 8'h04, 1'b0, 1);
    step();
    start = 1'b0;
    wait_until(r + 5);
    pause = 1'b1;
    push(r + 6, 8'h04, 1'b0, 2);
    step();
    pause = 1'b0;
    wait_until(r + 7);
    start = 1'b1;
    push(r + 8, 8'h04, 1'b0, 1);
    push(r + 9, 8'h03, 1'b0, 1);
    push(r + 13, 8'h02, 1'b0, 1);
    push(r + 17, 8'h01, 1'b0, 1);
    push(r + 21, 8'h00, 1'b1, 3);
    push(r + 22, 8'h00, 1'b0, 3);
    step();
    start = 1'b0;
    wait_until(r + 10);
    start = 1'b1;
    step();
    start = 1'b0;
    wait_until(r + 24);

    // Zero load expires on start; DONE ignores start; reload 2A
    do_load(8'h00);
    start = 1'b1;
    t0 = cyc + 1;
    push(t0, 8'h00, 1'b1, 3);
    push(t0 + 1, 8'h00, 1'b0, 3);
    step();
    start = 1'b0;
    step();
    start = 1'b1;
    step();
    start = 1'b0;
    step();
    do_load(8'h2A);
    pause = 1'b1;
    step();
    pause = 1'b0;

    // Load with pause mid-run, then full 255-step run
    start = 1'b1;
    t0 = cyc + 1;
    push(t0, 8'h2A, 1'b0, 1);
    push(t0 + 4, 8'h29, 1'b0, 1);
    step();
    start = 1'b0;
    wait_until(t0 + 5);
    load       = 1'b1;
    pause      = 1'b1;
    load_value = 8'hFF;
    push(t0 + 6, 8'hFF, 1'b0, 0);
    step();
    load  = 1'b0;
    pause = 1'b0;
    start = 1'b1;
    s0 = cyc + 1;
    push(s0, 8'hFF, 1'b0, 1);
    for (int k = 1; k <= 255; k++)
      push(s0 + 4 * k, 8'(255 - k), (k == 255), (k == 255) ? 3 : 1);
    push(s0 + 1021, 8'h00, 1'b0, 3);
    step();
    start = 1'b0;
    wait_until(s0 + 1024);

    // Asynchronous reset in the middle of a run
    do_load(8'h10);
    start = 1'b1;
    t0 = cyc + 1;
    push(t0, 8'h10, 1'b0, 1);
    push(t0 + 4, 8'h0F, 1'b0, 1);
    step();
    start = 1'b0;
    wait_until(t0 + 6);
    #2;
    clr = 1'b0;
    push(cyc + 1, 8'h00, 1'b0, 0);
    #1;
    chk("async_count", {24'd0, count}, 32'd0);
    chk("async_running", {31'd0, running}, 32'd0);
    chk("async_expired", {31'd0, expired}, 32'd0);
    chk("async_done", {31'd0, done}, 32'd0);
    chk("async_hex0", {25'd0, hex0}, 32'h40);
    chk("async_hex1", {25'd0, hex1}, 32'h40);
    step();
    step();
    clr = 1'b1;
    repeat (8) step();

    chk("pending_events", exp_q.size(), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/countdown_timer.md
Name: countdown_timer

Overview:
Loadable 8-bit down-counter with a programmable clock prescaler and a run/pause/done state machine. It is the down-counting counterpart to the team's 8-bit up-counter. It shares the same board wiring: KEY/SW drive the controls, and the count is shown on two seven-segment digits. A terminal-count pulse flags expiry to surrounding logic, such as an alarm LED or a lab FSM.

Parameters:
PRESCALE, 50000000, clk cycles per decrement while running (legal range 1..2^26; benches use 4)
PW, $clog2(PRESCALE) min 1, width of the internal prescaler counter (derived, not overridden)

Ports:
clk  input  1  system clock; all state updates on rising edge
clr  input  1  asynchronous active-low reset
load  input  1  synchronous load strobe (level, sampled each edge)
load_value  input  8  value copied into count on load
start  input  1  start / resume request
pause  input  1  pause request
count  output  8  current count value (registered)
running  output  1  high while state == RUN
expired  output  1  high while state == DONE
done  output  1  one-cycle pulse on entry to DONE
hex0  output  7  active-low segments for count[3:0]; bit0 = a ... bit6 = g
hex1  output  7  active-low segments for count[7:4]; same encoding

Behaviour:
- Reset (clr = 0, asynchronous, active-low; clock clk):
  - count = 0, prescaler = 0, state = IDLE, done = 0.
  - Therefore running = 0 and expired = 0; hex0 and hex1 show "0" (7'b1000000).
  - Reset mid-run abandons the count immediately, with no pending pulse.
- States: IDLE, RUN, PAUSED, DONE. State, count, prescaler and done are all registered.
- Priority at each edge: clr, then load, then state logic.
  - load = 1 in any state: count <= load_value, prescaler <= 0, state <= IDLE, done <= 0.
  - start and pause are ignored during that edge.
- IDLE:
  - start = 1 and count != 0: go to RUN, prescaler <= 0.
  - start = 1 and count == 0: go to DONE, done pulses.
  - pause is ignored.
- RUN:
  - pause = 1: go to PAUSED; prescaler is held, not cleared; no decrement that edge, even if a tick was due (pause beats tick).
  - Otherwise, if prescaler == PRESCALE-1: prescaler <= 0, count <= count-1.
  - Otherwise: prescaler <= prescaler+1.
  - If the decrement takes count from 1 to 0: state <= DONE and done <= 1 on the same edge, so done and count == 0 become visible together.
  - start is ignored.
- PAUSED:
  - start = 1: go to RUN; prescaler resumes from its held value, so no time is lost or gained.
  - pause is ignored.
  - count is frozen.
- DONE:
  - count holds 0; start and pause are ignored; only load or clr leaves.
  - done is high for exactly one cycle after entry; expired stays high for the whole of DONE.
- Latency:
  - start sampled at edge t0 (state becomes RUN): first decrement at edge t0+PRESCALE.
  - From load of N followed by start at t0: done asserts after edge t0 + N*PRESCALE.
- PRESCALE = 1: one decrement per RUN cycle.
- count never wraps; decrement below 0 is impossible because DONE is entered at 0.
- hex0 and hex1 are purely combinational from count.
  - Digits 0-9 and A-F use standard patterns: A, b, C, d, E, F.
  - Example: 0 = 1000000, 8 = 0000000, F = 0001110 (bits g..a).

Decomposition:
- Shared package holds:
  - the state encoding typedef (IDLE = 2'd0, RUN = 2'd1, PAUSED = 2'd2, DONE = 2'd3);
  - the seven-segment constant table for digits 0-F.
- One sub-module, seg7_decoder (4-bit in, 7-bit active-low out), instantiated twice.
- FSM, prescaler and count stay in the top.

Test Plan:
1. Reset with PRESCALE=4: assert clr=0 mid-operation -> count=0, running=0, expired=0, done=0 immediately; hex0=hex1=1000000.
2. Load 8'h03, start pulse at t0 -> count reads 2 after t0+4, 1 after t0+8, 0 after t0+12. done is high for exactly one cycle after edge t0+12, coincident with count=0; expired then stays 1.
3. Load 8'h05, start, pause 2 cycles after start, hold paused 10 cycles, then start -> count stays 5 while paused. First decrement lands 2 cycles after resume (prescaler held at 2). running=0 during PAUSED.
4. Pause asserted on the exact cycle prescaler==3 -> no decrement that edge; after resume, decrement occurs on the first RUN edge.
5. Load 8'h00, start -> DONE on the next edge, done pulses once, count stays 0. A following start is ignored. load 8'h2A -> IDLE, count=0x2A, hex1 shows "2", hex0 shows "A" (0001000).
6. Load asserted mid-RUN together with pause, load_value=8'hFF -> count=0xFF, state IDLE, prescaler 0, no done pulse. Start then runs the full 255*PRESCALE cycles to done.
